// File: rtl/rf_writeback_ctrl.sv
// Write-side initiator for the 8x8 register file.
// Buffers retiring results in an in-order queue, drives the file's write
// strobe as a two-cycle high/low pulse (commit on the falling edge), runs the
// file's reset load after system reset, and forwards still-queued results to
// the two operand readers.
module rf_writeback_ctrl #(
    parameter int DEPTH = 4,
    parameter int AW    = 3,
    parameter int DW    = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [AW-1:0] in_dest,
    input  logic [DW-1:0] in_data,
    input  logic [AW-1:0] src1,
    input  logic [AW-1:0] src2,
    output logic          fwd1_hit,
    output logic [DW-1:0] fwd1_data,
    output logic          fwd2_hit,
    output logic [DW-1:0] fwd2_data,
    output logic          rf_reset,
    output logic          rf_write,
    output logic [AW-1:0] rf_reg_write,
    output logic [DW-1:0] rf_writeback,
    output logic          busy
);

    // state   | meaning
    // INIT_HI | file reset load: first cycle strobe low (from reset), then strobe high
    // INIT_LO | strobe low; the falling edge loaded the file's reset values
    // IDLE    | queue empty, strobe low
    // WR_HI   | strobe high, head address/data presented
    // WR_LO   | strobe low after commit, address/data held

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;

    typedef enum logic [2:0] {
        INIT_HI,
        INIT_LO,
        IDLE,
        WR_HI,
        WR_LO
    } state_t;

    state_t state, state_nxt;

    logic [AW-1:0] dest_q [DEPTH];
    logic [DW-1:0] data_q [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;

    logic          push;
    logic          pop;
    logic          rf_reset_nxt;
    logic          rf_write_nxt;
    logic [AW-1:0] rf_reg_write_nxt;
    logic [DW-1:0] rf_writeback_nxt;

    assign in_ready = !reset && (count < CW'(DEPTH)) &&
                      (state != INIT_HI) && (state != INIT_LO);
    assign push     = in_valid && in_ready;
    assign busy     = reset || (state != IDLE) || (count != '0);

    // Next-state and next-output logic; the strobe/address/data registers
    // take the value belonging to the state being entered.
    always_comb begin
        state_nxt        = state;
        rf_reset_nxt     = rf_reset;
        rf_write_nxt     = rf_write;
        rf_reg_write_nxt = rf_reg_write;
        rf_writeback_nxt = rf_writeback;
        pop              = 1'b0;
        case (state)
            INIT_HI: begin
                // Entered from reset with the strobe low: raise it for one
                // cycle, then drop it in INIT_LO while rf_reset stays high.
                rf_reset_nxt = 1'b1;
                if (!rf_write) begin
                    rf_write_nxt = 1'b1;
                end else begin
                    rf_write_nxt = 1'b0;
                    state_nxt    = INIT_LO;
                end
            end
            INIT_LO: begin
                // rf_reset is released one edge after the strobe fell, so it
                // is never moving at the edge where the file samples it.
                rf_write_nxt = 1'b0;
                rf_reset_nxt = 1'b0;
                state_nxt    = IDLE;
            end
            IDLE: begin
                rf_reset_nxt = 1'b0;
                if (count != '0) begin
                    rf_reg_write_nxt = dest_q[rd_ptr];
                    rf_writeback_nxt = data_q[rd_ptr];
                    rf_write_nxt     = 1'b1;
                    state_nxt        = WR_HI;
                end
            end
            WR_HI: begin
                rf_write_nxt = 1'b0;
                pop          = 1'b1;
                state_nxt    = WR_LO;
            end
            WR_LO: begin
                if (count != '0) begin
                    rf_reg_write_nxt = dest_q[rd_ptr];
                    rf_writeback_nxt = data_q[rd_ptr];
                    rf_write_nxt     = 1'b1;
                    state_nxt        = WR_HI;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                rf_reset_nxt = 1'b1;
                rf_write_nxt = 1'b0;
                state_nxt    = INIT_HI;
            end
        endcase
    end

    // State, registered write-port outputs, queue pointers and occupancy.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= INIT_HI;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            rf_reset     <= 1'b1;
            rf_write     <= 1'b0;
            rf_reg_write <= '0;
            rf_writeback <= '0;
        end else begin
            state        <= state_nxt;
            rf_reset     <= rf_reset_nxt;
            rf_write     <= rf_write_nxt;
            rf_reg_write <= rf_reg_write_nxt;
            rf_writeback <= rf_writeback_nxt;
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (push && !pop) begin
                count <= count + CW'(1);
            end else if (!push && pop) begin
                count <= count - CW'(1);
            end
        end
    end

    // Queue storage; contents need no reset because count gates visibility.
    always_ff @(posedge clk) begin
        if (push) begin
            dest_q[wr_ptr] <= in_dest;
            data_q[wr_ptr] <= in_data;
        end
    end

    // Youngest-match forwarding: scan oldest to youngest so later hits win.
    always_comb begin
        fwd1_hit  = 1'b0;
        fwd1_data = '0;
        fwd2_hit  = 1'b0;
        fwd2_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (!reset && (CW'(i) < count)) begin
                if (dest_q[rd_ptr + PW'(i)] == src1) begin
                    fwd1_hit  = 1'b1;
                    fwd1_data = data_q[rd_ptr + PW'(i)];
                end
                if (dest_q[rd_ptr + PW'(i)] == src2) begin
                    fwd2_hit  = 1'b1;
                    fwd2_data = data_q[rd_ptr + PW'(i)];
                end
            end
        end
    end

endmodule

// File: tb/tb_rf_writeback_ctrl.sv
// Self-checking bench for rf_writeback_ctrl: a cycle table for reset/init and
// single writes, hand sequences for the multi-cycle corners, and a random run
// checked against a queue-based model of the write-back buffer.
module tb_rf_writeback_ctrl;

    localparam int DEPTH = 4;
    localparam int AW    = 3;
    localparam int DW    = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [AW-1:0] in_dest = '0;
    logic [DW-1:0] in_data = '0;
    logic [AW-1:0] src1 = '0;
    logic [AW-1:0] src2 = '0;
    logic          fwd1_hit;
    logic [DW-1:0] fwd1_data;
    logic          fwd2_hit;
    logic [DW-1:0] fwd2_data;
    logic          rf_reset;
    logic          rf_write;
    logic [AW-1:0] rf_reg_write;
    logic [DW-1:0] rf_writeback;
    logic          busy;

    always #5 clk = ~clk;

    rf_writeback_ctrl #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_dest      (in_dest),
        .in_data      (in_data),
        .src1         (src1),
        .src2         (src2),
        .fwd1_hit     (fwd1_hit),
        .fwd1_data    (fwd1_data),
        .fwd2_hit     (fwd2_hit),
        .fwd2_data    (fwd2_data),
        .rf_reset     (rf_reset),
        .rf_write     (rf_write),
        .rf_reg_write (rf_reg_write),
        .rf_writeback (rf_writeback),
        .busy         (busy)
    );

    typedef struct {
        logic          rst;
        logic          vld;
        logic [AW-1:0] dest;
        logic [DW-1:0] data;
        logic [AW-1:0] s1;
        logic [AW-1:0] s2;
        logic          e_rdy;
        logic          e_rrst;
        logic          e_wr;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_wdata;
        logic          e_busy;
        logic          e_h1;
        logic [DW-1:0] e_d1;
        logic          e_h2;
        logic [DW-1:0] e_d2;
    } vec_t;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    // Bench-side register file: observes falling strobe edges.
    logic          prev_wr = 1'b0;
    int            n_rst_loads = 0;
    logic [AW-1:0] c_addr[$];
    logic [DW-1:0] c_data[$];
    int            c_cyc[$];
    logic [DW-1:0] rf_file[8];

    // Random-phase model: results pushed but not yet committed, in order.
    logic [AW-1:0] qd[$];
    logic [DW-1:0] qv[$];
    logic [DW-1:0] rf_exp[8];
    int            stall = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    // Advance to the next falling clock edge and record any strobe fall.
    task automatic step();
        @(negedge clk);
        cyc++;
        if (prev_wr === 1'b1 && rf_write === 1'b0) begin
            if (rf_reset === 1'b1) begin
                n_rst_loads++;
                for (int r = 0; r < 8; r++) rf_file[r] = '0;
            end else begin
                c_addr.push_back(rf_reg_write);
                c_data.push_back(rf_writeback);
                c_cyc.push_back(cyc);
                rf_file[rf_reg_write] = rf_writeback;
            end
        end
        prev_wr = rf_write;
    endtask

    // One random-phase cycle: step, then reconcile commits with the model.
    task automatic sb_step(input logic will_push, input logic [AW-1:0] pd, input logic [DW-1:0] pv);
        int nlog;
        nlog = c_addr.size();
        step();
        if (c_addr.size() > nlog) begin
            chk("model entry present at commit", qd.size() != 0, 1);
            if (qd.size() != 0) begin
                chk("commit addr", c_addr[nlog], qd[0]);
                chk("commit data", c_data[nlog], qv[0]);
                void'(qd.pop_front());
                void'(qv.pop_front());
            end
            stall = 0;
        end else if (qd.size() != 0) begin
            stall++;
        end else begin
            stall = 0;
        end
        chk("cycles without commit while queued", stall > 1, 0);
        if (will_push) begin
            qd.push_back(pd);
            qv.push_back(pv);
            rf_exp[pd] = pv;
        end
    endtask

    function automatic vec_t mk(input logic rst, input logic vld, input logic [AW-1:0] d,
                                input logic [DW-1:0] dat, input logic [AW-1:0] s1,
                                input logic [AW-1:0] s2, input logic rdy, input logic rr,
                                input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                                input logic bsy, input logic h1, input logic [DW-1:0] d1,
                                input logic h2, input logic [DW-1:0] d2);
        vec_t v;
        v.rst = rst; v.vld = vld; v.dest = d; v.data = dat; v.s1 = s1; v.s2 = s2;
        v.e_rdy = rdy; v.e_rrst = rr; v.e_wr = wr; v.e_addr = a; v.e_wdata = wd;
        v.e_busy = bsy; v.e_h1 = h1; v.e_d1 = d1; v.e_h2 = h2; v.e_d2 = d2;
        return v;
    endfunction

    initial begin
        vec_t tbl[14];
        int   push_cyc[6];
        int   base;
        int   rl;
        logic exp_rdy;
        logic will_push;
        logic e_h1, e_h2;
        logic [DW-1:0] e_d1, e_d2;

        for (int r = 0; r < 8; r++) rf_file[r] = '0;

        //             rst vld dst dat    s1 s2 | rdy rr wr adr wdat  bsy h1 d1     h2 d2
        tbl[0]  = mk(1, 0, 0, 8'h00, 5, 6,   0, 1, 0, 0, 8'h00, 1, 0, 8'h00, 0, 8'h00);
        tbl[1]  = mk(1, 0, 0, 8'h00, 5, 6,   0, 1, 0, 0, 8'h00, 1, 0, 8'h00, 0, 8'h00);
        tbl[2]  = mk(1, 0, 0, 8'h00, 5, 6,   0, 1, 0, 0, 8'h00, 1, 0, 8'h00, 0, 8'h00);
        tbl[3]  = mk(0, 0, 0, 8'h00, 5, 6,   0, 1, 1, 0, 8'h00, 1, 0, 8'h00, 0, 8'h00);
        tbl[4]  = mk(0, 0, 0, 8'h00, 5, 6,   0, 1, 0, 0, 8'h00, 1, 0, 8'h00, 0, 8'h00);
        tbl[5]  = mk(0, 0, 0, 8'h00, 5, 6,   1, 0, 0, 0, 8'h00, 0, 0, 8'h00, 0, 8'h00);
        tbl[6]  = mk(0, 1, 5, 8'h3C, 5, 6,   1, 0, 0, 0, 8'h00, 1, 1, 8'h3C, 0, 8'h00);
        tbl[7]  = mk(0, 0, 0, 8'h00, 5, 6,   1, 0, 1, 5, 8'h3C, 1, 1, 8'h3C, 0, 8'h00);
        tbl[8]  = mk(0, 0, 0, 8'h00, 5, 6,   1, 0, 0, 5, 8'h3C, 1, 0, 8'h00, 0, 8'h00);
        tbl[9]  = mk(0, 0, 0, 8'h00, 5, 6,   1, 0, 0, 5, 8'h3C, 0, 0, 8'h00, 0, 8'h00);
        tbl[10] = mk(0, 1, 6, 8'h7E, 5, 6,   1, 0, 0, 5, 8'h3C, 1, 0, 8'h00, 1, 8'h7E);
        tbl[11] = mk(0, 0, 0, 8'h00, 5, 6,   1, 0, 1, 6, 8'h7E, 1, 0, 8'h00, 1, 8'h7E);
        tbl[12] = mk(0, 0, 0, 8'h00, 5, 6,   1, 0, 0, 6, 8'h7E, 1, 0, 8'h00, 0, 8'h00);
        tbl[13] = mk(0, 0, 0, 8'h00, 5, 6,   1, 0, 0, 6, 8'h7E, 0, 0, 8'h00, 0, 8'h00);

        for (int i = 0; i < 14; i++) begin
            reset    = tbl[i].rst;
            in_valid = tbl[i].vld;
            in_dest  = tbl[i].dest;
            in_data  = tbl[i].data;
            src1     = tbl[i].s1;
            src2     = tbl[i].s2;
            step();
            chk($sformatf("row%0d in_ready", i),     in_ready,     tbl[i].e_rdy);
            chk($sformatf("row%0d rf_reset", i),     rf_reset,     tbl[i].e_rrst);
            chk($sformatf("row%0d rf_write", i),     rf_write,     tbl[i].e_wr);
            chk($sformatf("row%0d rf_reg_write", i), rf_reg_write, tbl[i].e_addr);
            chk($sformatf("row%0d rf_writeback", i), rf_writeback, tbl[i].e_wdata);
            chk($sformatf("row%0d busy", i),         busy,         tbl[i].e_busy);
            chk($sformatf("row%0d fwd1_hit", i),     fwd1_hit,     tbl[i].e_h1);
            chk($sformatf("row%0d fwd1_data", i),    fwd1_data,    tbl[i].e_d1);
            chk($sformatf("row%0d fwd2_hit", i),     fwd2_hit,     tbl[i].e_h2);
            chk($sformatf("row%0d fwd2_data", i),    fwd2_data,    tbl[i].e_d2);
        end
        in_valid = 1'b0;
        chk("init reset loads", n_rst_loads, 1);
        chk("table commit count", c_addr.size(), 2);
        if (c_addr.size() == 2) begin
            chk("commit0 addr", c_addr[0], 5);
            chk("commit0 data", c_data[0], 8'h3C);
            chk("push-to-commit latency", c_cyc[0] - 7, 2);
            chk("commit1 addr", c_addr[1], 6);
            chk("commit1 data", c_data[1], 8'h7E);
        end

        // Back-to-back pushes until the queue fills; one commit every 2 cycles.
        base = c_addr.size();
        for (int k = 0; k < 6; k++) begin
            in_valid = 1'b1;
            in_dest  = AW'(k + 1);
            in_data  = DW'((k + 1) * 8'h11);
            step();
            push_cyc[k] = cyc;
            chk($sformatf("fill push%0d in_ready", k), in_ready, (k == 5) ? 1'b0 : 1'b1);
        end
        in_valid = 1'b0;
        step();
        chk("in_ready after pop from full", in_ready, 1);
        for (int t = 0; t < 40 && busy !== 1'b0; t++) step();
        chk("fill drained busy", busy, 0);
        chk("fill commit count", c_addr.size() - base, 6);
        if (c_addr.size() - base == 6) begin
            for (int k = 0; k < 6; k++) begin
                chk($sformatf("fill commit%0d addr", k), c_addr[base + k], k + 1);
                chk($sformatf("fill commit%0d data", k), c_data[base + k], (k + 1) * 8'h11);
                chk($sformatf("fill commit%0d cycle", k), c_cyc[base + k], push_cyc[0] + 2 + 2 * k);
            end
        end

        // Two results for r3: the younger one forwards and lands last.
        src1 = 3;
        in_valid = 1'b1; in_dest = 3; in_data = 8'hA0;
        step();
        chk("r3 fwd hit (A0 queued)", fwd1_hit, 1);
        chk("r3 fwd data (A0 queued)", fwd1_data, 8'hA0);
        in_dest = 3; in_data = 8'hB0;
        step();
        in_valid = 1'b0;
        chk("r3 fwd data (both queued)", fwd1_data, 8'hB0);
        step();
        chk("r3 fwd data (A0 popped)", fwd1_data, 8'hB0);
        step();
        chk("r3 fwd hit (B0 at head)", fwd1_hit, 1);
        chk("r3 fwd data (B0 at head)", fwd1_data, 8'hB0);
        step();
        chk("r3 fwd hit (both popped)", fwd1_hit, 0);
        chk("r3 fwd data (both popped)", fwd1_data, 0);
        for (int t = 0; t < 10 && busy !== 1'b0; t++) step();
        chk("r3 final value", rf_file[3], 8'hB0);

        // Reset while WR_HI with three entries queued.
        base = c_addr.size();
        rl   = n_rst_loads;
        src1 = 2;
        in_valid = 1'b1;
        in_dest = 1; in_data = 8'h91; step();
        in_dest = 2; in_data = 8'h92; step();
        in_dest = 2; in_data = 8'h93; step();
        in_dest = 7; in_data = 8'h97; step();
        chk("pre-reset rf_write", rf_write, 1);
        chk("pre-reset fwd data", fwd1_data, 8'h93);
        in_valid = 1'b0;
        reset    = 1'b1;
        step();
        chk("reset in WR_HI rf_write", rf_write, 0);
        chk("reset in WR_HI rf_reset", rf_reset, 1);
        chk("reset in WR_HI in_ready", in_ready, 0);
        chk("reset in WR_HI fwd hit", fwd1_hit, 0);
        chk("reset in WR_HI busy", busy, 1);
        reset = 1'b0;
        step();
        chk("re-init rf_write high", rf_write, 1);
        chk("re-init in_ready", in_ready, 0);
        step();
        chk("re-init rf_write low", rf_write, 0);
        chk("re-init rf_reset held", rf_reset, 1);
        step();
        chk("re-init rf_reset released", rf_reset, 0);
        chk("re-init in_ready", in_ready, 1);
        chk("re-init queue cleared (busy)", busy, 0);
        chk("re-init queue cleared (fwd)", fwd1_hit, 0);
        for (int t = 0; t < 6; t++) step();
        chk("data commits around reset", c_addr.size() - base, 1);
        chk("reset loads around reset", n_rst_loads - rl, 2);

        // Random traffic against the queue model.
        for (int r = 0; r < 8; r++) rf_exp[r] = rf_file[r];
        for (int n = 0; n < 3000; n++) begin
            in_valid = ($urandom_range(0, 99) < 60);
            in_dest  = AW'($urandom);
            in_data  = DW'($urandom);
            src1     = AW'($urandom);
            src2     = AW'($urandom);
            #1;
            exp_rdy = (qd.size() < DEPTH);
            e_h1 = 1'b0; e_d1 = '0; e_h2 = 1'b0; e_d2 = '0;
            for (int j = qd.size() - 1; j >= 0; j--) begin
                if (!e_h1 && qd[j] == src1) begin e_h1 = 1'b1; e_d1 = qv[j]; end
                if (!e_h2 && qd[j] == src2) begin e_h2 = 1'b1; e_d2 = qv[j]; end
            end
            chk("rand in_ready", in_ready, exp_rdy);
            chk("rand fwd1_hit", fwd1_hit, e_h1);
            chk("rand fwd1_data", fwd1_data, e_d1);
            chk("rand fwd2_hit", fwd2_hit, e_h2);
            chk("rand fwd2_data", fwd2_data, e_d2);
            if (qd.size() != 0) chk("rand busy while queued", busy, 1);
            will_push = in_valid && exp_rdy;
            sb_step(will_push, in_dest, in_data);
        end
        in_valid = 1'b0;
        for (int t = 0; t < 40 && (qd.size() != 0 || busy !== 1'b0); t++) sb_step(1'b0, '0, '0);
        chk("rand drained model queue", qd.size(), 0);
        chk("rand drained busy", busy, 0);
        for (int r = 0; r < 8; r++) chk($sformatf("rand final r%0d", r), rf_file[r], rf_exp[r]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
